adc_avg_detect: RTL and testbench
=================================

Name: adc_avg_detect

Overview:
- Downstream consumer of the ADS7883 controller.
- Takes each new signed 12-bit conversion, qualified by the controller's data-update flag, into a power-of-two moving-average filter.
- Runs a hysteresis threshold detector with a debounce hold counter on the averaged value.
- Outputs the averaged sample, a one-cycle valid strobe and a debounced alarm level for the neck-check decision logic.

Parameters:
- AVG_LOG2, 3, log2 of averaging window depth (window = 8 samples); legal 1..5.
- TH_HIGH, 12'sd1000, signed average strictly above this counts toward alarm set.
- TH_LOW, 12'sd800, signed average strictly below this counts toward alarm clear; TH_LOW <= TH_HIGH required.
- HOLD_CNT, 4, consecutive qualifying averages needed to change alarm state; legal 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en_filt  in  1  filter enable; low flushes window and detector
- adc_data  in  12  signed conversion result from ADC controller
- data_upflag  in  1  ADC data-update flag; rising edge marks a new sample
- avg_data  out  12  signed moving average, registered
- avg_valid  out  1  one-cycle strobe when avg_data updates
- alarm  out  1  debounced threshold alarm level
- peak_data  out  12  signed peak average (optional feature)
- peak_clr  in  1  synchronous peak clear (optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values: avg_data=0, avg_valid=0, alarm=0, peak_data=-2048.
  - All internal storage also resets to 0: window RAM/regs, running sum, write pointer, fill count, hold count, upflag delay.
  - State resets to FILL.
- Sample detection: sample_evt = data_upflag & ~data_upflag_d.
  - A flag held high for several cycles yields exactly one sample.
  - adc_data is captured on the sample_evt cycle; it is stable because the controller updates it before raising the flag.
- Running sum: signed, width 12+AVG_LOG2.
  - Cycle 0: sample_evt; buf[wr_ptr] <= sample; sum <= sum + sample - buf[wr_ptr].
  - wr_ptr increments modulo 2^AVG_LOG2, wrapping silently.
  - Sum never overflows by construction.
- Average: avg_data = sum >>> AVG_LOG2 (arithmetic shift, truncation toward minus infinity), registered cycle 1.
  - avg_valid pulses on cycle 1 only when fill count has reached 2^AVG_LOG2.
  - Latency: 2 clocks from data_upflag rising edge to avg_valid.
- Fill count saturates at 2^AVG_LOG2. No avg_valid during FILL; avg_data still tracks the partial sum.
- Detector state machine, evaluated on each avg_valid:
  - FILL -> NORMAL when the window first becomes full (same cycle as the first avg_valid; that average is also evaluated).
  - NORMAL:
    - avg > TH_HIGH increments hold; otherwise hold = 0.
    - When hold reaches HOLD_CNT: go to ALARM, alarm=1, hold=0.
  - ALARM:
    - avg < TH_LOW increments hold; otherwise hold = 0.
    - When hold reaches HOLD_CNT: go to NORMAL, alarm=0, hold=0.
  - Values between TH_LOW and TH_HIGH reset hold in both states.
  - alarm changes in the cycle after the qualifying avg_valid (latency 3 from the flag).
- en_filt low: highest priority, synchronous.
  - Clears the window, sum, wr_ptr, fill count, hold, alarm and avg_valid; state goes to FILL.
  - sample_evt is ignored while low.
  - avg_data holds its last value.
  - The upflag delay register keeps tracking, so a flag already high when enable rises is not taken as a sample.
- Reset mid-operation (rst_n or en_filt) abandons any partial window; the next full window needs 2^AVG_LOG2 fresh samples.

Optional Feature:
- Macro: ADC_AVG_PEAK_EN.
- Defined:
  - On each avg_valid, if avg_data > peak_data then peak_data <= avg_data.
  - peak_clr high sets peak_data to -2048 and takes priority over an update in the same cycle.
  - en_filt low also clears peak_data.
- Undefined: peak_data tied to 12'sd0; peak_clr ignored; no peak register synthesised.

Decomposition:
- Shared package (adc_pkg) holds:
  - ADC_W = 12 constant;
  - the signed sample typedef;
  - detector state enum FILL/NORMAL/ALARM;
  - the -2048 minimum-value constant.
- One natural sub-module, adc_avg_window: circular buffer, running sum and fill count, with sample in/strobe and avg/valid out.
- The detector FSM and peak logic stay in the top.

Test Plan:
- Reset, then 8 samples of 12'sd400 with en_filt=1 -> no avg_valid on samples 1..7; on sample 8 avg_valid pulses 2 clocks after the flag edge with avg_data=400; alarm=0.
- Full window of 400, then 8 samples of 1200 -> averages 500, 600 … 1100, 1200. Once the average exceeds 1000 (1100 is the first), alarm sets after the 4th consecutive qualifying average (1200 in this stream, so the 4-long run needs further 1200 samples).
- Hold data_upflag high for 10 cycles with a single edge -> exactly one sample taken and at most one avg_valid.
- In ALARM, feed averages 700, 700, 900, 700, 700, 700, 700 -> the 900 resets hold; alarm clears only after the final four 700s.
- Negative data: window of -2047 and -2048 mixed, sum -16380 -> avg_data = -2048 (arithmetic truncation), no overflow.
- en_filt pulsed low for 1 cycle mid-window in ALARM -> alarm=0, state FILL, 8 fresh samples needed. With ADC_AVG_PEAK_EN: peak_data=-2048 after the pulse, then tracks the max; peak_clr and avg_valid in the same cycle -> -2048.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC averaging / threshold-detect slice.
package adc_pkg;

    localparam int ADC_W = 12;

    typedef logic signed [ADC_W-1:0] sample_t;

    typedef enum logic [1:0] {
        FILL,
        NORMAL,
        ALARM
    } det_state_e;

    localparam sample_t SAMPLE_MIN = 12'sh800;

endpackage

// File: rtl/adc_avg_window.sv
// Power-of-two moving-average window: circular sample store, running sum,
// fill counter and a registered average with a full-window valid strobe.
module adc_avg_window
    import adc_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [ADC_W-1:0] in_data,
    output logic signed [ADC_W-1:0] avg_data,
    output logic                    avg_valid
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = ADC_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(DEPTH);

    sample_t                 win_q [DEPTH];
    sample_t                 win_d [DEPTH];
    logic [AVG_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AVG_LOG2:0]       fill_q, fill_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    upd_q, upd_d;
    sample_t                 avg_q, avg_d;
    logic                    valid_q, valid_d;

    always_comb begin
        win_d    = win_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_d    = sum_q;
        upd_d    = 1'b0;
        avg_d    = avg_q;
        valid_d  = 1'b0;
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_d[i] = '0;
            end
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_d    = '0;
        end else begin
            if (in_valid) begin
                // Oldest sample leaves the sum as the new one enters.
                win_d[wr_ptr_q] = in_data;
                sum_d    = sum_q + SUM_W'(in_data) - SUM_W'(win_q[wr_ptr_q]);
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FULL) begin
                    fill_d = fill_q + 1'b1;
                end
                upd_d = 1'b1;
            end
            if (upd_q) begin
                avg_d   = sample_t'(sum_q >>> AVG_LOG2);
                valid_d = (fill_q == FULL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
            upd_q    <= 1'b0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            upd_q    <= upd_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
        end
    end

    assign avg_data  = avg_q;
    assign avg_valid = valid_q;

endmodule

// File: rtl/adc_avg_detect.sv
// Averaged ADC sample with debounced hysteresis alarm.
// Optional peak tracker enabled by defining ADC_AVG_PEAK_EN.
module adc_avg_detect
    import adc_pkg::*;
#(
    parameter int unsigned            AVG_LOG2 = 3,
    parameter logic signed [ADC_W-1:0] TH_HIGH = 12'sd1000,
    parameter logic signed [ADC_W-1:0] TH_LOW  = 12'sd800,
    parameter int unsigned            HOLD_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_filt,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic                    data_upflag,
    output logic signed [ADC_W-1:0] avg_data,
    output logic                    avg_valid,
    output logic                    alarm,
    output logic signed [ADC_W-1:0] peak_data,
    input  logic                    peak_clr
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_CNT);

    logic       upflag_q, upflag_d;
    logic       sample_evt;
    sample_t    win_avg;
    logic       win_valid;
    det_state_e state_q;
    logic [7:0] hold_q;
    logic [7:0] hold_inc;
    logic       alarm_q;
    logic       over_th, under_th;

    // Delay keeps tracking while disabled so a flag already high at enable is not a sample.
    always_comb begin
        upflag_d   = data_upflag;
        sample_evt = data_upflag & ~upflag_q & en_filt;
        hold_inc   = hold_q + 8'd1;
        over_th    = (win_avg > TH_HIGH);
        under_th   = (win_avg < TH_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upflag_q <= 1'b0;
        end else begin
            upflag_q <= upflag_d;
        end
    end

    adc_avg_window #(
        .AVG_LOG2(AVG_LOG2)
    ) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (~en_filt),
        .in_valid (sample_evt),
        .in_data  (adc_data),
        .avg_data (win_avg),
        .avg_valid(win_valid)
    );

    // The first valid average leaves FILL and is judged with NORMAL rules.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            hold_q  <= '0;
            alarm_q <= 1'b0;
        end else if (!en_filt) begin
            state_q <= FILL;
            hold_q  <= '0;
            alarm_q <= 1'b0;
        end else if (win_valid) begin
            case (state_q)
                FILL, NORMAL: begin
                    if (!over_th) begin
                        state_q <= NORMAL;
                        hold_q  <= '0;
                    end else if (hold_inc == HOLD_MAX) begin
                        state_q <= ALARM;
                        hold_q  <= '0;
                        alarm_q <= 1'b1;
                    end else begin
                        state_q <= NORMAL;
                        hold_q  <= hold_inc;
                    end
                end
                ALARM: begin
                    if (!under_th) begin
                        hold_q <= '0;
                    end else if (hold_inc == HOLD_MAX) begin
                        state_q <= NORMAL;
                        hold_q  <= '0;
                        alarm_q <= 1'b0;
                    end else begin
                        hold_q <= hold_inc;
                    end
                end
                default: begin
                    state_q <= FILL;
                    hold_q  <= '0;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADC_AVG_PEAK_EN
    sample_t peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (!en_filt || peak_clr) begin
            peak_d = SAMPLE_MIN;
        end else if (win_valid && (win_avg > peak_q)) begin
            peak_d = win_avg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= SAMPLE_MIN;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_data = peak_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_data       = '0;
`endif

    assign avg_data  = win_avg;
    assign avg_valid = win_valid;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_adc_avg_detect.sv
// Directed bench for adc_avg_detect (default parameters; peak checks follow ADC_AVG_PEAK_EN).
module tb_adc_avg_detect;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en_filt;
    logic signed [11:0] adc_data;
    logic               data_upflag;
    logic signed [11:0] avg_data;
    logic               avg_valid;
    logic               alarm;
    logic signed [11:0] peak_data;
    logic               peak_clr;

    int total = 0;
    int bad   = 0;
    int vld2, avg2, npulse, acc;

`ifdef ADC_AVG_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    adc_avg_detect dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_filt    (en_filt),
        .adc_data   (adc_data),
        .data_upflag(data_upflag),
        .avg_data   (avg_data),
        .avg_valid  (avg_valid),
        .alarm      (alarm),
        .peak_data  (peak_data),
        .peak_clr   (peak_clr)
    );

    always #5 clk = ~clk;

    function automatic int pk(input int v);
        return PEAK_ON ? v : 0;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sample: flag high for 'hi' cycles; avg/valid captured two edges after the rise.
    task automatic put(input int v, input int hi, input bit pclr);
        @(negedge clk);
        adc_data    = 12'(v);
        data_upflag = 1'b1;
        npulse      = 0;
        for (int k = 1; k <= hi + 3; k++) begin
            @(negedge clk);
            if (k == hi) data_upflag = 1'b0;
            if (avg_valid) npulse++;
            if (k == 2) begin
                vld2     = int'(avg_valid);
                avg2     = int'(avg_data);
                peak_clr = pclr;
            end
            if (k == 3) peak_clr = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int prep_v[8] = '{1200, 1200, 400, 1200, 1200, 1200, 1200, 1200};
        int tv[7]     = '{-2000, 1200, 2000, -400, 1200, 1200, 1200};
        int ta[7]     = '{700, 700, 900, 700, 700, 700, 700};

        rst_n = 1'b0; en_filt = 1'b0; data_upflag = 1'b0; peak_clr = 1'b0; adc_data = '0;
        repeat (3) @(negedge clk);
        check("rst_avg", int'(avg_data), 0);
        check("rst_valid", int'(avg_valid), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_peak", int'(peak_data), pk(-2048));
        rst_n = 1'b1;
        @(negedge clk);
        en_filt = 1'b1;

        // Fill with 400: partial average tracks, no strobe until the 8th sample.
        put(400, 1, 1'b0);
        check("fill1_avg", avg2, 50);
        acc = npulse;
        for (int i = 2; i <= 7; i++) begin
            put(400, 1, 1'b0);
            acc += npulse;
        end
        check("fill_nopulse", acc, 0);
        put(400, 1, 1'b0);
        check("full_valid", vld2, 1);
        check("full_avg", avg2, 400);
        check("full_alarm", int'(alarm), 0);

        // Ramp to 1200; first >1000 average is 1100 on the 7th.
        for (int i = 1; i <= 8; i++) begin
            put(1200, 1, 1'b0);
            check("ramp_avg", avg2, 400 + 100 * i);
            check("ramp_valid", vld2, 1);
        end
        check("ramp_alarm", int'(alarm), 0);
        put(1200, 1, 1'b0);
        check("hold3_alarm", int'(alarm), 0);
        put(1200, 1, 1'b0);
        check("hold4_alarm", int'(alarm), 1);
        check("ramp_peak", int'(peak_data), pk(1200));

        // Long flag: one sample of 0 gives 8400/8; a second would give 900.
        put(0, 10, 1'b0);
        check("held_pulses", npulse, 1);
        check("held_avg", avg2, 1050);
        check("held_alarm", int'(alarm), 1);

        // Condition window so the clear sequence reaches exact averages.
        for (int i = 0; i < 8; i++) put(prep_v[i], 1, 1'b0);
        check("prep_avg", avg2, 1100);
        check("prep_alarm", int'(alarm), 1);
        for (int i = 0; i < 7; i++) begin
            put(tv[i], 1, 1'b0);
            check("clr_avg", avg2, ta[i]);
            if (i == 5) check("clr_hold3_alarm", int'(alarm), 1);
        end
        check("clr_alarm", int'(alarm), 0);

        // Flush with the flag already high; enable rising must not take it.
        @(negedge clk);
        en_filt = 1'b0; adc_data = 12'sd2047; data_upflag = 1'b1;
        @(negedge clk);
        check("flush_avg_hold", int'(avg_data), 700);
        check("flush_valid", int'(avg_valid), 0);
        check("flush_peak", int'(peak_data), pk(-2048));
        en_filt = 1'b1;
        repeat (2) @(negedge clk);
        data_upflag = 1'b0;
        @(negedge clk);
        check("en_edge_nosample", int'(avg_data), 700);

        // Negative extremes: arithmetic truncation toward minus infinity.
        put(-2047, 1, 1'b0);
        check("neg1_avg", avg2, -256);
        check("neg1_valid", vld2, 0);
        for (int i = 0; i < 3; i++) put(-2047, 1, 1'b0);
        for (int i = 0; i < 4; i++) put(-2048, 1, 1'b0);
        check("neg_avg", avg2, -2048);
        check("neg_valid", vld2, 1);
        check("neg_peak", int'(peak_data), pk(-2048));

        // Climb to 2000 and set the alarm on the 10th sample.
        for (int k = 1; k <= 10; k++) begin
            put(2000, 1, 1'b0);
            if (k == 1) check("climb1_avg", avg2, -1542);
            if (k == 7) check("climb7_avg", avg2, 1494);
            if (k == 9) check("climb9_alarm", int'(alarm), 0);
        end
        check("climb_alarm", int'(alarm), 1);
        check("climb_peak", int'(peak_data), pk(2000));

        // Single-cycle enable drop while in ALARM.
        @(negedge clk);
        en_filt = 1'b0;
        @(negedge clk);
        check("pulse_alarm", int'(alarm), 0);
        check("pulse_avg_hold", int'(avg_data), 2000);
        check("pulse_peak", int'(peak_data), pk(-2048));
        en_filt = 1'b1;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            put(2000, 1, 1'b0);
            acc += npulse;
        end
        check("refill_nopulse", acc, 0);
        put(2000, 1, 1'b0);
        check("refill_valid", vld2, 1);
        check("refill_avg", avg2, 2000);
        check("refill_alarm", int'(alarm), 0);
        check("refill_peak", int'(peak_data), pk(2000));

        // Clear coincides with a larger average: clear wins.
        put(2047, 1, 1'b1);
        check("pclr_avg", avg2, 2005);
        check("pclr_peak", int'(peak_data), pk(-2048));
        put(2047, 1, 1'b0);
        check("after_pclr_avg", avg2, 2011);
        check("after_pclr_peak", int'(peak_data), pk(2011));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
